// File: rtl/toggle3pos_debounce.sv
// Debouncer for the 2-bit code of a 3-position toggle: two-flop synchronizer, then an
// ena-paced run counter that accepts a position after STABLE_TICKS equal samples.
module toggle3pos_debounce #(
  parameter int STABLE_TICKS = 8,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] in,
  output logic [1:0] out,
  output logic       chg,
  output logic       up,
  output logic       dn,
  output logic       fault
);

  localparam logic [1:0]       POS_CENTER = 2'b01;
  localparam logic [1:0]       POS_BAD    = 2'b11;
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ACC    = CNT_W'(STABLE_TICKS - 2);

  logic [1:0]       s1_q, s2_q;
  logic [1:0]       cand_q, cand_d;
  logic [1:0]       out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chg_q, chg_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             fault_q, fault_d;

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    fault_d = fault_q;
    chg_d   = 1'b0;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    if (ena) begin
      if (s2_q != cand_q) begin
        cand_d = s2_q;
        cnt_d  = '0;
        if (cand_q == POS_BAD) fault_d = 1'b0;
      end else if (cnt_q < CNT_SAT) begin
        cnt_d = cnt_q + 1'b1;
        // The step from STABLE_TICKS-2 to saturation is the one and only acceptance point of a run.
        if (cnt_q == CNT_ACC) begin
          if (cand_q == POS_BAD) begin
            fault_d = 1'b1;
          end else if (cand_q != out_q) begin
            out_d = cand_q;
            chg_d = 1'b1;
            up_d  = (cand_q < out_q);
            dn_d  = (cand_q > out_q);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= POS_CENTER;
      s2_q    <= POS_CENTER;
      cand_q  <= POS_CENTER;
      out_q   <= POS_CENTER;
      cnt_q   <= CNT_SAT;
      chg_q   <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      s1_q    <= in;
      s2_q    <= s1_q;
      cand_q  <= cand_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      chg_q   <= chg_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      fault_q <= fault_d;
    end
  end

  assign out   = out_q;
  assign chg   = chg_q;
  assign up    = up_q;
  assign dn    = dn_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_toggle3pos_debounce.sv
// Bench for toggle3pos_debounce: two instances (STABLE_TICKS 4 and 8) share one stimulus,
// each checked every cycle against a sliding-window model, plus directed literal checks.
module tb_toggle3pos_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [1:0] tin;

  logic [1:0] out_w   [2];
  logic       chg_w   [2];
  logic       up_w    [2];
  logic       dn_w    [2];
  logic       fault_w [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int ST = (g == 0) ? 4 : 8;

    toggle3pos_debounce #(.STABLE_TICKS(ST), .CNT_W(16)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .in    (tin),
      .out   (out_w[g]),
      .chg   (chg_w[g]),
      .up    (up_w[g]),
      .dn    (dn_w[g]),
      .fault (fault_w[g])
    );

    // Model: a position is accepted when the last ST samples all equal it and the
    // sample just before that window did not; history is center-filled at reset.
    logic [1:0] m_sync [2];
    logic [1:0] m_hist [$];
    logic [1:0] m_out;
    logic       m_chg, m_up, m_dn, m_fault;
    bit         m_init = 0;

    initial forever begin
      logic [1:0] v;
      bit         all_eq;
      @(posedge clk);
      m_chg = 1'b0; m_up = 1'b0; m_dn = 1'b0;
      if (!rst_n) begin
        m_sync[0] = 2'b01;
        m_sync[1] = 2'b01;
        m_hist.delete();
        for (int i = 0; i <= ST; i++) m_hist.push_back(2'b01);
        m_out   = 2'b01;
        m_fault = 1'b0;
        m_init  = 1;
      end else begin
        if (ena) begin
          v = m_sync[1];
          m_hist.push_back(v);
          void'(m_hist.pop_front());
          all_eq = 1;
          for (int i = 1; i <= ST; i++) if (m_hist[i] != v) all_eq = 0;
          if (v != 2'b11) m_fault = 1'b0;
          if (all_eq && m_hist[0] != v) begin
            if (v == 2'b11) m_fault = 1'b1;
            else if (v != m_out) begin
              m_chg = 1'b1;
              m_up  = (v < m_out);
              m_dn  = (v > m_out);
              m_out = v;
            end
          end
        end
        m_sync[1] = m_sync[0];
        m_sync[0] = tin;
      end
    end

    initial forever begin
      @(negedge clk);
      if (m_init)
        check($sformatf("model_cmp_st%0d", ST),
              {out_w[g], chg_w[g], up_w[g], dn_w[g], fault_w[g]},
              {m_out, m_chg, m_up, m_dn, m_fault});
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; tin = 2'b10;
    tick(3);
    check("rst_out0",   6'(out_w[0]), 6'(2'b01));
    check("rst_out1",   6'(out_w[1]), 6'(2'b01));
    check("rst_flags0", 6'({chg_w[0], up_w[0], dn_w[0], fault_w[0]}), 6'd0);
    check("rst_flags1", 6'({chg_w[1], up_w[1], dn_w[1], fault_w[1]}), 6'd0);

    // Release with in=10: ST=4 accepts at edge 6, ST=8 at edge 10.
    rst_n = 1'b1;
    tick(5);
    check("rel_pre_out0", 6'(out_w[0]), 6'(2'b01));
    tick(1);
    check("rel_out0", 6'(out_w[0]), 6'(2'b10));
    check("rel_dn0",  6'({chg_w[0], up_w[0], dn_w[0]}), 6'(3'b101));
    tick(1);
    check("rel_dn0_off", 6'(dn_w[0]), 6'd0);
    tick(3);
    check("rel_out1", 6'(out_w[1]), 6'(2'b10));
    check("rel_dn1",  6'(dn_w[1]), 6'd1);

    // Clean move 01 -> 00.
    tin = 2'b01; tick(12);
    check("ctr_out0", 6'(out_w[0]), 6'(2'b01));
    check("ctr_out1", 6'(out_w[1]), 6'(2'b01));
    tin = 2'b00;
    tick(5);
    check("mv_pre_out0", 6'(out_w[0]), 6'(2'b01));
    tick(1);
    check("mv_out0",   6'(out_w[0]), 6'(2'b00));
    check("mv_strb0",  6'({chg_w[0], up_w[0], dn_w[0]}), 6'(3'b110));
    tick(1);
    check("mv_up0_off", 6'(up_w[0]), 6'd0);
    tick(3);
    check("mv_out1", 6'(out_w[1]), 6'(2'b00));
    check("mv_up1",  6'(up_w[1]), 6'd1);

    // Bounce 10/01 every 2 clks, ending at 01: no acceptance.
    tin = 2'b01; tick(12);
    for (int i = 0; i < 20; i++) begin
      tin = i[0] ? 2'b01 : 2'b10;
      tick(2);
    end
    tick(12);
    check("bnc_out0", 6'(out_w[0]), 6'(2'b01));
    check("bnc_out1", 6'(out_w[1]), 6'(2'b01));
    // Bounce again, then settle at 10.
    for (int i = 0; i < 20; i++) begin
      tin = i[0] ? 2'b01 : 2'b10;
      tick(2);
    end
    tin = 2'b10;
    tick(5);
    check("bset_pre_out0", 6'(out_w[0]), 6'(2'b01));
    tick(1);
    check("bset_out0", 6'(out_w[0]), 6'(2'b10));
    check("bset_dn0",  6'(dn_w[0]), 6'd1);
    tick(4);
    check("bset_out1", 6'(out_w[1]), 6'(2'b10));

    // Slow ena (every 10th clk), 10 -> 00; ST=8 accepts on the 8th sample.
    tin = 2'b00;
    for (int k = 0; k < 7; k++) begin
      ena = 1'b0; tick(9);
      ena = 1'b1; tick(1);
    end
    check("slow_pre_out1", 6'(out_w[1]), 6'(2'b10));
    ena = 1'b0; tick(9);
    ena = 1'b1; tick(1);
    check("slow_out1",  6'(out_w[1]), 6'(2'b00));
    check("slow_strb1", 6'({chg_w[1], up_w[1], dn_w[1]}), 6'(3'b110));
    ena = 1'b0; tick(1);
    check("slow_up1_off", 6'(up_w[1]), 6'd0);

    // Invalid code held, then released.
    ena = 1'b1; tin = 2'b11;
    tick(9);
    check("inv_pre_fault1", 6'(fault_w[1]), 6'd0);
    tick(1);
    check("inv_fault1", 6'(fault_w[1]), 6'd1);
    check("inv_out1",   6'(out_w[1]), 6'(2'b00));
    tick(10);
    check("inv_hold_fault1", 6'(fault_w[1]), 6'd1);
    check("inv_hold_out0",   6'(out_w[0]), 6'(2'b00));
    tin = 2'b01;
    tick(2);
    check("inv_rel_pre1", 6'(fault_w[1]), 6'd1);
    tick(1);
    check("inv_clr_fault1", 6'(fault_w[1]), 6'd0);
    check("inv_clr_fault0", 6'(fault_w[0]), 6'd0);
    tick(12);

    // ena gated off while the input moves.
    ena = 1'b0; tin = 2'b10;
    tick(50);
    tin = 2'b00;
    tick(50);
    check("gate_out0", 6'(out_w[0]), 6'(2'b01));
    check("gate_out1", 6'(out_w[1]), 6'(2'b01));
    ena = 1'b1;
    tick(3);
    check("gate_pre_out0", 6'(out_w[0]), 6'(2'b01));
    tick(1);
    check("gate_out0_acc", 6'(out_w[0]), 6'(2'b00));
    check("gate_up0",      6'(up_w[0]), 6'd1);
    tick(3);
    check("gate_pre_out1", 6'(out_w[1]), 6'(2'b01));
    tick(1);
    check("gate_out1_acc", 6'(out_w[1]), 6'(2'b00));

    // Reset in the middle of a run toward 10.
    tin = 2'b10;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    check("mrst_out0", 6'(out_w[0]), 6'(2'b01));
    check("mrst_chg0", 6'(chg_w[0]), 6'd0);
    rst_n = 1'b1;
    tick(5);
    check("mrst_pre_out0", 6'(out_w[0]), 6'(2'b01));
    tick(1);
    check("mrst_acc_out0", 6'(out_w[0]), 6'(2'b10));
    check("mrst_dn0",      6'(dn_w[0]), 6'd1);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
